mat_mult_param: RTL and testbench
=================================

MAT_MULT_PARAM -- requirements
Module: mat_mult_param

Interface
REQ-001 Parameter N, default 2, meaning matrix dimension (square NxN); legal range 2..4.
REQ-002 Parameter DW, default 2, meaning unsigned element width in bits; legal range 1..8.
REQ-003 Parameter RW, default 2*DW+$clog2(N), meaning result element width; not overridden by users.
REQ-004 clk  input  1  meaning the single clock; all logic rising-edge triggered.
REQ-005 rst  input  1  meaning synchronous, active-high reset.
REQ-006 load_in  input  1  meaning request to capture both operand matrices.
REQ-007 a_flat  input  N*N*DW  meaning matrix A; element (i,j) at [(i*N+j)*DW +: DW].
REQ-008 b_flat  input  N*N*DW  meaning matrix B; same packing as a_flat.
REQ-009 ready  output  1  meaning block idle and able to accept load_in.
REQ-010 result_out  output  N*N*RW  meaning C=A*B; element (i,j) at [(i*N+j)*RW +: RW].
REQ-011 valid  output  1  meaning single-cycle strobe that result_out is freshly updated.

Function
REQ-012 The block SHALL implement states IDLE, CALC and DONE, using a single DWxDW multiplier with an RW-bit accumulator.
REQ-013 ready SHALL be high exactly when state is IDLE.
REQ-014 At an edge with state IDLE and load_in=1, the block SHALL register a_flat/b_flat, clear the i/j/k counters and accumulator, and enter CALC.
REQ-015 In CALC, each edge SHALL add a[i][k]*b[k][j] to the accumulator, iterating k innermost, then j, then i, all from 0 to N-1.
REQ-016 When k=N-1, the sum SHALL be written to internal buffer element (i,j) and the accumulator cleared.
REQ-017 CALC SHALL last exactly N^3 edges; on the edge completing element (N-1,N-1) the buffer SHALL be copied to result_out and state SHALL enter DONE.
REQ-018 valid SHALL be high only in DONE, i.e. for one cycle beginning N^3+1 edges after the capturing edge (9 edges for N=2).
REQ-019 DONE SHALL return to IDLE on the next edge unconditionally.
REQ-020 result_out SHALL remain stable between DONE updates, including throughout CALC.
REQ-021 load_in while state is CALC or DONE SHALL be ignored and SHALL not alter captured operands.
REQ-022 Arithmetic SHALL be unsigned with no overflow; RW is sized for the all-ones case (N*(2^DW-1)^2).
REQ-023 Operand inputs SHALL be don't-care except on the capturing edge.

Reset
REQ-024 At a rising edge with rst=1, state SHALL become IDLE, counters/accumulator/buffer zero, result_out zero, valid 0; ready reads 1 from the following cycle.
REQ-025 rst SHALL take priority over load_in and SHALL abort any CALC in progress without updating result_out.

Configuration
REQ-026 With macro MAT_MULT_OVERRUN_EN defined, an extra output overrun (1 bit) SHALL be present, set when load_in=1 while ready=0, sticky until rst.
REQ-027 Without MAT_MULT_OVERRUN_EN, the overrun port and its logic SHALL be absent; behaviour otherwise identical.

Verification
REQ-028 N=2,DW=2, all elements of A and B =3, one load_in pulse -> valid 9 edges later, result_out=20'h94A52 (each element 18).
REQ-029 N=2: A=identity, B=[[1,2],[3,0]] -> result_out elements (0,0)=1,(0,1)=2,(1,0)=3,(1,1)=0; valid high exactly one cycle.
REQ-030 N=4,DW=4, all elements 15 -> every result element =900 after 65 edges, no truncation.
REQ-031 load_in pulsed during CALC with different operands -> ignored, first result unchanged; with MAT_MULT_OVERRUN_EN overrun=1 until rst.
REQ-032 rst asserted mid-CALC -> valid never asserts, result_out=0, ready=1 next cycle; new load then completes correctly.
REQ-033 Back-to-back loads with load_in held high -> second capture on the edge after DONE, two valid pulses each N^3+1 edges after their capture edges.

Source files
------------

// File: rtl/mat_mult_param.sv
// NxN unsigned matrix multiplier: one DWxDW MAC per clock, result published after N^3 cycles.
// Optional sticky overrun flag when compiled with MAT_MULT_OVERRUN_EN.
module mat_mult_param #(
  parameter int N  = 2,
  parameter int DW = 2,
  parameter int RW = 2*DW + $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_in,
  input  logic [N*N*DW-1:0]    a_flat,
  input  logic [N*N*DW-1:0]    b_flat,
  output logic                 ready,
  output logic [N*N*RW-1:0]    result_out,
  output logic                 valid
`ifdef MAT_MULT_OVERRUN_EN
  , output logic               overrun
`endif
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t              state;
  logic [N*N*DW-1:0]   a_q;
  logic [N*N*DW-1:0]   b_q;
  logic [CW-1:0]       i_q;
  logic [CW-1:0]       j_q;
  logic [CW-1:0]       k_q;
  logic [RW-1:0]       acc_q;
  logic [N*N*RW-1:0]   buf_q;
  logic [N*N*RW-1:0]   buf_next;
  logic [DW-1:0]       a_el;
  logic [DW-1:0]       b_el;
  logic [2*DW-1:0]     prod;
  logic [RW-1:0]       sum;

  assign ready = (state == IDLE);
  assign valid = (state == DONE);

  // buf_next carries the element finishing this cycle so the final copy to
  // result_out includes element (N-1,N-1) on the same edge.
  always_comb begin
    a_el     = a_q[(int'(i_q)*N + int'(k_q))*DW +: DW];
    b_el     = b_q[(int'(k_q)*N + int'(j_q))*DW +: DW];
    prod     = a_el * b_el;
    sum      = acc_q + RW'(prod);
    buf_next = buf_q;
    if (k_q == LAST)
      buf_next[(int'(i_q)*N + int'(j_q))*RW +: RW] = sum;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      i_q        <= '0;
      j_q        <= '0;
      k_q        <= '0;
      acc_q      <= '0;
      buf_q      <= '0;
      result_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load_in) begin
            a_q   <= a_flat;
            b_q   <= b_flat;
            i_q   <= '0;
            j_q   <= '0;
            k_q   <= '0;
            acc_q <= '0;
            state <= CALC;
          end
        end
        CALC: begin
          buf_q <= buf_next;
          if (k_q == LAST) begin
            acc_q <= '0;
            k_q   <= '0;
            if (j_q == LAST) begin
              j_q <= '0;
              if (i_q == LAST) begin
                i_q        <= '0;
                result_out <= buf_next;
                state      <= DONE;
              end else begin
                i_q <= i_q + CW'(1);
              end
            end else begin
              j_q <= j_q + CW'(1);
            end
          end else begin
            acc_q <= sum;
            k_q   <= k_q + CW'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MAT_MULT_OVERRUN_EN
  always_ff @(posedge clk) begin
    if (rst)
      overrun <= 1'b0;
    else if (load_in && state != IDLE)
      overrun <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_mat_mult_param.sv
// Bench for mat_mult_param: cycle model + result scoreboard on an N=2/DW=2 instance,
// directed all-ones case on an N=4/DW=4 instance. Overrun checked when MAT_MULT_OVERRUN_EN is defined.
module tb_mat_mult_param;

  logic         clk;
  logic         rst;
  logic         load_in;
  logic [7:0]   a_flat;
  logic [7:0]   b_flat;
  logic         ready;
  logic [19:0]  result_out;
  logic         valid;

  logic         load4;
  logic [63:0]  a4;
  logic [63:0]  b4;
  logic         ready4;
  logic [159:0] result4;
  logic         valid4;

`ifdef MAT_MULT_OVERRUN_EN
  logic ovr;
  logic ovr4;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int valid_pulses = 0;
  logic chk_en = 1'b0;

  mat_mult_param #(.N(2), .DW(2)) dut (
    .clk(clk), .rst(rst), .load_in(load_in), .a_flat(a_flat), .b_flat(b_flat),
    .ready(ready), .result_out(result_out), .valid(valid)
`ifdef MAT_MULT_OVERRUN_EN
    , .overrun(ovr)
`endif
  );

  mat_mult_param #(.N(4), .DW(4)) dut4 (
    .clk(clk), .rst(rst), .load_in(load4), .a_flat(a4), .b_flat(b4),
    .ready(ready4), .result_out(result4), .valid(valid4)
`ifdef MAT_MULT_OVERRUN_EN
    , .overrun(ovr4)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      $error("check %s", tag);
    end
  endtask

  function automatic logic [159:0] mm(input int n, input int dw, input int rw,
                                      input logic [63:0] a, input logic [63:0] b);
    logic [159:0] r;
    logic [63:0]  mask;
    int           acc;
    int           av;
    int           bv;
    r    = '0;
    mask = (64'd1 << dw) - 64'd1;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < n; j++) begin
        acc = 0;
        for (int k = 0; k < n; k++) begin
          av  = int'((a >> ((i*n + k)*dw)) & mask);
          bv  = int'((b >> ((k*n + j)*dw)) & mask);
          acc = acc + av*bv;
        end
        r = r | (160'(acc) << ((i*n + j)*rw));
      end
    end
    return r;
  endfunction

  // Cycle-level reference for the N=2 instance; the scoreboard entry is pushed on capture.
  typedef enum {M_IDLE, M_CALC, M_DONE} mstate_t;
  typedef struct {
    logic [19:0] res;
    int          cap;
  } exp_t;

  exp_t        sb[$];
  mstate_t     m_st = M_IDLE;
  int          m_cnt = 0;
  logic [19:0] m_result = '0;
  logic        m_ovr = 1'b0;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_st     = M_IDLE;
      m_result = '0;
      m_ovr    = 1'b0;
      sb.delete();
    end else begin
      if (load_in && m_st != M_IDLE) m_ovr = 1'b1;
      case (m_st)
        M_IDLE: if (load_in) begin
          sb.push_back('{res: 20'(mm(2, 2, 5, 64'(a_flat), 64'(b_flat))), cap: cyc});
          m_cnt = 0;
          m_st  = M_CALC;
        end
        M_CALC: begin
          m_cnt++;
          if (m_cnt == 8) begin
            m_st = M_DONE;
            if (sb.size() > 0) m_result = sb[0].res;
          end
        end
        default: m_st = M_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("ready", 160'(ready), 160'(m_st == M_IDLE));
      check("valid", 160'(valid), 160'(m_st == M_DONE));
      check("result_stable", 160'(result_out), 160'(m_result));
`ifdef MAT_MULT_OVERRUN_EN
      check("overrun", 160'(ovr), 160'(m_ovr));
`endif
      if (valid === 1'b1) begin
        exp_t e;
        valid_pulses++;
        check("sb_nonempty", 160'(sb.size() > 0), 160'(1));
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("sb_result", 160'(result_out), 160'(e.res));
          // latency counted with the capturing edge as edge 1
          check("sb_latency", 160'(cyc - e.cap + 1), 160'(9));
        end
      end
    end
  end

  task automatic pulse_load(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    a_flat  = a;
    b_flat  = b;
    load_in = 1'b1;
    @(negedge clk);
    load_in = 1'b0;
    a_flat  = '0;
    b_flat  = '0;
  endtask

  task automatic wait_valid(input string tag, input int start, output int n);
    n = start;
    while (valid !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_no_timeout"}, 160'(valid === 1'b1), 160'(1));
  endtask

  initial begin
    int          n;
    int          vp;
    logic [7:0]  a1;
    logic [7:0]  b1;
    logic [7:0]  a2;
    logic [7:0]  b2;
    logic [159:0] all900;

    rst = 1'b1; load_in = 1'b0; a_flat = '0; b_flat = '0;
    load4 = 1'b0; a4 = '0; b4 = '0;
    @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_ready", 160'(ready), 160'(1));
    check("rst_result", 160'(result_out), 160'(0));
    check("rst_ready4", 160'(ready4), 160'(1));
    @(negedge clk);
    rst = 1'b0;

    // all threes -> every element 18
    pulse_load(8'hFF, 8'hFF);
    wait_valid("t1", 1, n);
    check("t1_edges", 160'(n), 160'(9));
    check("t1_result", 160'(result_out), 160'(20'h94A52));
    @(negedge clk);
    check("t1_valid_one_cycle", 160'(valid), 160'(0));

    // identity * [[1,2],[3,0]]
    pulse_load(8'h41, 8'h39);
    wait_valid("t2", 1, n);
    check("t2_edges", 160'(n), 160'(9));
    check("t2_result", 160'(result_out), 160'({5'd0, 5'd3, 5'd2, 5'd1}));
    @(negedge clk);
    check("t2_valid_one_cycle", 160'(valid), 160'(0));

    // load during CALC is ignored
    a1 = 8'($urandom); b1 = 8'($urandom);
    pulse_load(a1, b1);
    repeat (2) @(negedge clk);
    a_flat = ~a1; b_flat = ~b1; load_in = 1'b1;
    @(negedge clk);
    load_in = 1'b0; a_flat = '0; b_flat = '0;
    wait_valid("t3", 4, n);
    check("t3_edges", 160'(n), 160'(9));
    check("t3_result", 160'(result_out), mm(2, 2, 5, 64'(a1), 64'(b1)));
    repeat (3) @(negedge clk);
`ifdef MAT_MULT_OVERRUN_EN
    check("t3_overrun_sticky", 160'(ovr), 160'(1));
`endif
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t3_rst_result", 160'(result_out), 160'(0));
`ifdef MAT_MULT_OVERRUN_EN
    check("t3_overrun_cleared", 160'(ovr), 160'(0));
`endif

    // reset mid-CALC aborts, then a fresh load completes
    vp = valid_pulses;
    pulse_load(8'hFF, 8'hAA);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t4_ready", 160'(ready), 160'(1));
    check("t4_result", 160'(result_out), 160'(0));
    repeat (10) @(negedge clk);
    check("t4_no_valid", 160'(valid_pulses), 160'(vp));
    a1 = 8'($urandom); b1 = 8'($urandom);
    pulse_load(a1, b1);
    wait_valid("t4b", 1, n);
    check("t4b_edges", 160'(n), 160'(9));
    check("t4b_result", 160'(result_out), mm(2, 2, 5, 64'(a1), 64'(b1)));
    repeat (2) @(negedge clk);

    // load_in held: second capture on the edge after DONE
    vp = valid_pulses;
    a1 = 8'($urandom); b1 = 8'($urandom);
    a2 = 8'($urandom); b2 = 8'($urandom);
    @(negedge clk);
    a_flat = a1; b_flat = b1; load_in = 1'b1;
    @(negedge clk);
    a_flat = a2; b_flat = b2;
    repeat (10) @(negedge clk);
    load_in = 1'b0; a_flat = '0; b_flat = '0;
    check("t5_second_result_pending", 160'(result_out), mm(2, 2, 5, 64'(a1), 64'(b1)));
    repeat (12) @(negedge clk);
    check("t5_two_pulses", 160'(valid_pulses), 160'(vp + 2));
    check("t5_second_result", 160'(result_out), mm(2, 2, 5, 64'(a2), 64'(b2)));

    // random operands through the scoreboard
    for (int t = 0; t < 5; t++) begin
      pulse_load(8'($urandom), 8'($urandom));
      wait_valid("rand", 1, n);
      check("rand_edges", 160'(n), 160'(9));
      @(negedge clk);
    end

    // N=4, DW=4 all-ones: each element 4*15*15 = 900
    all900 = '0;
    for (int e = 0; e < 16; e++) all900 = all900 | (160'(900) << (e*10));
    @(negedge clk);
    a4 = '1; b4 = '1; load4 = 1'b1;
    @(negedge clk);
    load4 = 1'b0; a4 = '0; b4 = '0;
    n = 1;
    while (valid4 !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("n4_edges", 160'(n), 160'(65));
    check("n4_result", result4, all900);
    check("n4_model", result4, mm(4, 4, 10, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF));
    @(negedge clk);
    check("n4_valid_drop", 160'(valid4), 160'(0));
    check("n4_ready", 160'(ready4), 160'(1));
`ifdef MAT_MULT_OVERRUN_EN
    check("n4_overrun", 160'(ovr4), 160'(0));
`endif

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
